// File: rtl/wt_cache_pkg.sv
// Shared write-through cache geometry used by the dcache blocks.
package wt_cache_pkg;

  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_SET_ASSOC    = 8;

endpackage

// File: rtl/wt_dcache_rd_arb_pkg.sv
// Types and constants for the dcache read-port arbiter.
package wt_dcache_rd_arb_pkg;
  import wt_cache_pkg::*;

  localparam int unsigned DCACHE_RD_PORTS = 3;

  typedef struct packed {
    logic                           tag_only;
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] off;
  } dcache_rd_req_t;

endpackage

// File: rtl/wt_dcache_rd_arb_chk.sv
// Protocol properties of the dcache read arbiter.
module wt_dcache_rd_arb_chk #(
  parameter int unsigned NumPorts = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                wr_busy_i,
  input logic [NumPorts-1:0] rd_req_i,
  input logic [NumPorts-1:0] rd_ack_o,
  input logic [NumPorts-1:0] rd_rvld_o
);

  a_ack_onehot:  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_ack_o));
  a_rvld_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rd_rvld_o));
  a_ack_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni) (rd_ack_o & ~rd_req_i) == {NumPorts{1'b0}});
  a_no_ack_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) wr_busy_i |-> (rd_ack_o == {NumPorts{1'b0}}));

endmodule

// File: rtl/wt_dcache_rd_arb_rr_pick.sv
// One-hot picker: first requester at or after ptr (wrapping), or lowest index when RrEn=0.
module wt_dcache_rd_arb_rr_pick #(
  parameter int unsigned NumPorts = 3,
  parameter bit          RrEn     = 1'b1,
  parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req,
  input  logic [IdxW-1:0]     ptr,
  output logic [NumPorts-1:0] gnt
);

  logic            found_s;
  logic [IdxW-1:0] start_s;
  logic [31:0]     cand_s;

  // Scan from the start point, wrapping explicitly so NumPorts need not be a power of two
  always_comb begin
    gnt     = {NumPorts{1'b0}};
    found_s = 1'b0;
    cand_s  = 32'd0;
    start_s = RrEn ? ptr : {IdxW{1'b0}};
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand_s = 32'(start_s) + k;
      if (cand_s >= NumPorts) begin
        cand_s = cand_s - NumPorts;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IdxW-1:0]]) begin
        gnt[cand_s[IdxW-1:0]] = 1'b1;
        found_s               = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Shares the dcache read port among NumPorts load-side controllers; writes/refills win over reads.
module wt_dcache_rd_arb
  import wt_cache_pkg::*;
  import wt_dcache_rd_arb_pkg::*;
#(
  parameter int unsigned NumPorts = DCACHE_RD_PORTS,
  parameter bit          RrEn     = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clr_i,
  input  logic                                    wr_busy_i,
  input  logic [NumPorts-1:0]                     rd_req_i,
  input  logic [NumPorts-1:0]                     rd_tag_only_i,
  input  logic [NumPorts*DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i,
  input  logic [NumPorts*DCACHE_OFFSET_WIDTH-1:0] rd_off_i,
  input  logic [NumPorts*DCACHE_TAG_WIDTH-1:0]    rd_tag_i,
  output logic [NumPorts-1:0]                     rd_ack_o,
  output logic [NumPorts-1:0]                     rd_rvld_o,
  output logic [63:0]                             rd_data_o,
  output logic [DCACHE_SET_ASSOC-1:0]             rd_vld_bits_o,
  output logic [DCACHE_SET_ASSOC-1:0]             rd_hit_oh_o,
  output logic                                    mem_rd_en_o,
  output logic                                    mem_rd_tag_only_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]          mem_rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]          mem_rd_off_o,
  output logic [DCACHE_TAG_WIDTH-1:0]             mem_rd_tag_o,
  input  logic [63:0]                             mem_rd_data_i,
  input  logic [DCACHE_SET_ASSOC-1:0]             mem_rd_vld_bits_i,
  input  logic [DCACHE_SET_ASSOC-1:0]             mem_rd_hit_oh_i
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  dcache_rd_req_t        req_s [NumPorts];
  dcache_rd_req_t        sel_s;
  logic [NumPorts-1:0]   pick_gnt_s;
  logic [NumPorts-1:0]   ack_s;
  logic [IdxW-1:0]       win_idx_s;
  logic [IdxW-1:0]       next_ptr_s;
  logic [DCACHE_TAG_WIDTH-1:0] tag_s;
  logic [IdxW-1:0]       rr_ptr_r;
  logic [NumPorts-1:0]   gnt_r;

  for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
    assign req_s[p].tag_only = rd_tag_only_i[p];
    assign req_s[p].idx      = rd_idx_i[p*DCACHE_CL_IDX_WIDTH +: DCACHE_CL_IDX_WIDTH];
    assign req_s[p].off      = rd_off_i[p*DCACHE_OFFSET_WIDTH +: DCACHE_OFFSET_WIDTH];
  end

  wt_dcache_rd_arb_rr_pick #(
    .NumPorts (NumPorts),
    .RrEn     (RrEn),
    .IdxW     (IdxW)
  ) i_pick (
    .req (rd_req_i),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s)
  );

  // Grant suppression while the write/refill path owns the memory
  always_comb begin
    if (wr_busy_i) begin
      ack_s = {NumPorts{1'b0}};
    end else begin
      ack_s = pick_gnt_s;
    end
  end

  // AND-OR muxes keyed by one-hot vectors; all-zero select yields zero fields
  always_comb begin
    sel_s     = {$bits(dcache_rd_req_t){1'b0}};
    win_idx_s = {IdxW{1'b0}};
    tag_s     = {DCACHE_TAG_WIDTH{1'b0}};
    for (int unsigned p = 0; p < NumPorts; p++) begin
      sel_s     = sel_s | (req_s[p] & {$bits(dcache_rd_req_t){ack_s[p]}});
      win_idx_s = win_idx_s | (IdxW'(p) & {IdxW{ack_s[p]}});
      tag_s     = tag_s | (rd_tag_i[p*DCACHE_TAG_WIDTH +: DCACHE_TAG_WIDTH] & {DCACHE_TAG_WIDTH{gnt_r[p]}});
    end
  end

  // Pointer moves one past the winner with an explicit wrap to port 0
  always_comb begin
    if (win_idx_s == IdxW'(NumPorts - 1)) begin
      next_ptr_s = {IdxW{1'b0}};
    end else begin
      next_ptr_s = win_idx_s + IdxW'(1);
    end
  end

  // Round-robin pointer and response-valid registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= {IdxW{1'b0}};
      gnt_r    <= {NumPorts{1'b0}};
    end else if (clr_i) begin
      rr_ptr_r <= {IdxW{1'b0}};
      gnt_r    <= {NumPorts{1'b0}};
    end else begin
      gnt_r <= ack_s;
      if (|ack_s) begin
        rr_ptr_r <= next_ptr_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign rd_ack_o          = ack_s;
  assign rd_rvld_o         = gnt_r;
  assign rd_data_o         = mem_rd_data_i;
  assign rd_vld_bits_o     = mem_rd_vld_bits_i;
  assign rd_hit_oh_o       = mem_rd_hit_oh_i;
  assign mem_rd_en_o       = |ack_s;
  assign mem_rd_tag_only_o = sel_s.tag_only;
  assign mem_rd_idx_o      = sel_s.idx;
  assign mem_rd_off_o      = sel_s.off;
  assign mem_rd_tag_o      = tag_s;

endmodule

// File: doc/wt_dcache_rd_arb.md
Name: wt_dcache_rd_arb

Overview:
- Shares the single L1 dcache read port between NumPorts load-side controllers: load-unit controllers and PTW.
- Per-cycle round-robin grant; the write/refill path has priority over all reads.
- Accepts a request's tag one cycle after grant, routes it to the tag compare, and returns data, valid bits and hit vector tagged with a one-hot response valid.
- Sits between the per-port read controllers and the dcache memory block.

Parameters:
- NumPorts, 3, number of read requesters; must be >= 2.
- RrEn, 1'b1, 1 = round-robin; 0 = fixed priority, port 0 highest.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clr_i  in  1  synchronous clear, active high
- wr_busy_i  in  1  write/refill owns the memory this cycle; no read grant
- rd_req_i  in  NumPorts  read request per port
- rd_tag_only_i  in  NumPorts  tag lookup only, no data
- rd_idx_i  in  NumPorts x DCACHE_CL_IDX_WIDTH  cache line index
- rd_off_i  in  NumPorts x DCACHE_OFFSET_WIDTH  byte offset
- rd_tag_i  in  NumPorts x DCACHE_TAG_WIDTH  tag; valid one cycle after ack
- rd_ack_o  out  NumPorts  one-hot grant, combinational, same cycle as request
- rd_rvld_o  out  NumPorts  one-hot response valid, cycle after ack
- rd_data_o  out  64  read data, broadcast to all ports
- rd_vld_bits_o  out  DCACHE_SET_ASSOC  way valid bits, broadcast
- rd_hit_oh_o  out  DCACHE_SET_ASSOC  one-hot hit vector, broadcast
- mem_rd_en_o  out  1  memory read enable
- mem_rd_tag_only_o  out  1  granted port's tag_only
- mem_rd_idx_o  out  DCACHE_CL_IDX_WIDTH  granted port's index
- mem_rd_off_o  out  DCACHE_OFFSET_WIDTH  granted port's offset
- mem_rd_tag_o  out  DCACHE_TAG_WIDTH  tag of the port granted last cycle
- mem_rd_data_i  in  64  memory data, cycle after enable
- mem_rd_vld_bits_i  in  DCACHE_SET_ASSOC  way valid bits, cycle after enable
- mem_rd_hit_oh_i  in  DCACHE_SET_ASSOC  hit vector computed from mem_rd_tag_o

Behaviour:
- Clock/reset: one clock clk_i; reset is asynchronous, active-low rst_ni.
- Reset values: rr_ptr_q=0; gnt_q=0; rd_rvld_o=0.
  - All outputs are combinational from these, so all acks are 0 with no request.
- Grant (cycle N):
  - If wr_busy_i=1: rd_ack_o=0, mem_rd_en_o=0.
  - Otherwise, among ports with rd_req_i=1, select the first port at index >= rr_ptr_q, wrapping modulo NumPorts.
  - If RrEn=0: select the lowest index.
  - rd_ack_o = one-hot of the winner; mem_rd_en_o = |rd_ack_o.
  - mem_rd_idx_o, mem_rd_off_o, mem_rd_tag_only_o = winner's fields.
  - With no grant, these fields are 0.
- Pointer update:
  - On a grant to port i: rr_ptr_q <= (i==NumPorts-1) ? 0 : i+1.
  - No grant: pointer held.
  - Wrap from NumPorts-1 to 0 is explicit; no power-of-two assumption.
- Response (cycle N+1):
  - gnt_q <= rd_ack_o.
  - mem_rd_tag_o = rd_tag_i[index of gnt_q]; 0 if gnt_q=0.
  - rd_rvld_o = gnt_q.
  - rd_data_o, rd_vld_bits_o, rd_hit_oh_o pass through combinationally.
  - Latency from ack to data: exactly 1 cycle.
- Throughput:
  - One grant per cycle; back-to-back grants allowed to the same or different ports.
  - A grant in N+1 overlaps the response of N.
- Requester contract:
  - Requests are not required to stay asserted; each cycle is re-arbitrated.
  - A port that dropped rd_req_i after ack still receives rd_rvld_o.
  - Kill handling is the requester's job; the arbiter always produces the response.
- wr_busy_i in N+1 does not affect the response of a grant made in N.
  - Collision detection is the requester's duty.
- clr_i:
  - Next edge sets rr_ptr_q=0 and gnt_q=0.
  - A response pending in that cycle is still driven that cycle; it is dropped afterwards.
- Reset mid-operation: gnt_q is cleared asynchronously, so rd_rvld_o=0 immediately.
- Starvation: with RrEn=1, a continuously requesting port is granted within NumPorts non-busy cycles.
- Assertions:
  - $onehot0(rd_ack_o) and $onehot0(rd_rvld_o).
  - rd_ack_o[i] implies rd_req_i[i].
  - No ack while wr_busy_i.

Decomposition:
- Existing package, reused: wt_cache_pkg supplies DCACHE_CL_IDX_WIDTH, DCACHE_OFFSET_WIDTH, DCACHE_TAG_WIDTH and DCACHE_SET_ASSOC.
- New package additions:
  - typedef dcache_rd_req_t {tag_only, idx, off}, used for the port arrays.
  - localparam DCACHE_RD_PORTS = 3.
- One sub-module: rr_arb_tree from common_cells for the grant (external priority pointer, lock disabled).
  - Alternatively a local wt_dcache_rr_pick with inputs req, ptr and output one-hot gnt.
- Flop, pointer and tag mux logic stays in the top module.

Test Plan:
- Idle: rd_req_i=000 for 5 cycles -> rd_ack_o=000, mem_rd_en_o=0, rd_rvld_o=000.
- Single request: rd_req_i=010, idx=0x2A, tag 0x1234 next cycle, mem_rd_data_i=0xDEADBEEF -> ack=010 in N, mem_rd_idx_o=0x2A; in N+1 mem_rd_tag_o=0x1234, rd_rvld_o=010, rd_data_o=0xDEADBEEF.
- All ports continuously requesting, RrEn=1 -> acks 001, 010, 100, 001 …; each rd_rvld_o one cycle after its ack.
- wr_busy_i=1 for 3 cycles with rd_req_i=111 -> no acks, rr_ptr_q unchanged; first grant after busy goes to the port at the held pointer.
- Grant in N, then wr_busy_i=1 in N+1 -> rd_rvld_o still asserted in N+1 with memory data passed through.
- Async reset asserted in N+1 after a grant -> rd_rvld_o=0 immediately; after release the first grant goes to port 0.
